// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the sequence keeper
//
// Holds the round-engine state encoding, the symbol type, generator request
// codes and the legal symbol range, plus small helpers used by the RTL.
package seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_SETTLE1,
        S_SETTLE2,
        S_STORE,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_INPUT,
        S_WIN,
        S_FAIL
    } state_t;

    typedef logic [2:0] symbol_t;

    localparam logic [3:0] STEP_REQ  = 4'b0001;
    localparam logic [3:0] STEP_IDLE = 4'b0000;

    localparam symbol_t SYM_MIN = 3'd1;
    localparam symbol_t SYM_MAX = 3'd4;

    // A symbol is usable only inside 1..4; 0 and 5..7 are discarded.
    function automatic logic sym_ok(input symbol_t s);
        return (s >= SYM_MIN) && (s <= SYM_MAX);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sequence_keeper_if.sv
// rtl/sequence_keeper_if.sv - bundle of the keeper's generator, player and display signals
//
// master : the sequence keeper (drives step, show_*, level, busy, win, fail)
// slave  : the surrounding system (drives start, randnum, randReady, btn_*)
import seq_pkg::*;

interface sequence_keeper_if #(
    parameter int MAX_LEN = 16
);
    logic                      start;
    logic [3:0]                step;
    symbol_t                   randnum;
    logic                      randReady;
    logic                      btn_valid;
    symbol_t                   btn_val;
    symbol_t                   show_val;
    logic                      show_valid;
    logic [$clog2(MAX_LEN):0]  level;
    logic                      busy;
    logic                      win;
    logic                      fail;

    modport master (
        input  start, randnum, randReady, btn_valid, btn_val,
        output step, show_val, show_valid, level, busy, win, fail
    );

    modport slave (
        output start, randnum, randReady, btn_valid, btn_val,
        input  step, show_val, show_valid, level, busy, win, fail
    );
endinterface

// File: rtl/sequence_keeper_tick_timer.sv
// rtl/sequence_keeper_tick_timer.sv - loadable down-counter for show/gap/timeout phases
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   load     : load value into the counter this cycle
//   value    : phase length in clocks (0 leaves the timer idle)
//   done     : high during the last clock of the loaded phase
module tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    // Loading N at the phase-entry edge gives counts N..1, i.e. N clocks.
    assign done = (cnt == W'(1));

endmodule

// File: rtl/sequence_keeper.sv
// rtl/sequence_keeper.sv - Simon-style round engine between symbol generator and display
//
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   bus.master : start, generator handshake (step/randnum/randReady),
//                player entry (btn_valid/btn_val), display (show_val/show_valid),
//                status (level/busy/win/fail)
import seq_pkg::*;

module sequence_keeper #(
    parameter int MAX_LEN       = 16,
    parameter int SHOW_TICKS    = 25000000,
    parameter int GAP_TICKS     = 12500000,
    parameter int TIMEOUT_TICKS = 0
) (
    input  logic              clk,
    input  logic              rst,
    sequence_keeper_if.master bus
);
    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(max3(SHOW_TICKS, GAP_TICKS, TIMEOUT_TICKS) + 1);
    localparam bit TO_EN = (TIMEOUT_TICKS > 0);

    state_t         state;
    symbol_t        seq [MAX_LEN];
    logic [LW-1:0]  len;
    logic [LW-1:0]  i;
    logic [LW-1:0]  idx;

    logic [3:0]     step_q;
    symbol_t        show_val_q;
    logic           show_valid_q;
    logic           busy_q;
    logic           win_q;
    logic           fail_q;

    logic           tmr_load;
    logic [TW-1:0]  tmr_val;
    logic           tmr_done;

    logic [LW-1:0]  last;
    logic [LW-1:0]  i_nxt;
    logic           btn_match;
    logic           timeout_hit;

    assign last        = len - LW'(1);
    assign i_nxt       = i + LW'(1);
    assign btn_match   = (bus.btn_val == seq[idx[AW-1:0]]);
    assign timeout_hit = TO_EN && tmr_done;

    // The one timer serves show, gap and timeout; it is loaded on exactly the
    // edges where the FSM enters (or re-arms) one of those phases.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            S_STORE: begin
                if (sym_ok(bus.randnum)) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(SHOW_TICKS);
                end
            end
            S_SHOW_ON: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GAP_TICKS);
                end
            end
            S_SHOW_OFF: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = (i == last) ? TW'(TIMEOUT_TICKS) : TW'(SHOW_TICKS);
                end
            end
            S_INPUT: begin
                if (bus.btn_valid && btn_match && (idx != last)) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TIMEOUT_TICKS);
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    tick_timer #(
        .W (TW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_val),
        .done  (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            len          <= '0;
            i            <= '0;
            idx          <= '0;
            step_q       <= STEP_IDLE;
            show_val_q   <= '0;
            show_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            win_q        <= 1'b0;
            fail_q       <= 1'b0;
        end else if (bus.start) begin
            // start wins over everything and doubles as the abort.
            state        <= S_REQ;
            len          <= '0;
            i            <= '0;
            idx          <= '0;
            step_q       <= STEP_REQ;
            show_val_q   <= '0;
            show_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            win_q        <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            win_q  <= 1'b0;
            fail_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy_q <= 1'b0;
                end
                S_REQ: begin
                    if (bus.randReady) begin
                        state  <= S_SETTLE1;
                        step_q <= STEP_IDLE;
                    end
                end
                S_SETTLE1: state <= S_SETTLE2;
                S_SETTLE2: state <= S_STORE;
                S_STORE: begin
                    if (sym_ok(bus.randnum)) begin
                        seq[len[AW-1:0]] <= bus.randnum;
                        len              <= len + LW'(1);
                        i                <= '0;
                        state            <= S_SHOW_ON;
                        // seq[0] is not written yet when this is the first symbol.
                        show_val_q       <= (len == '0) ? bus.randnum : seq[0];
                        show_valid_q     <= 1'b1;
                    end else begin
                        state  <= S_REQ;
                        step_q <= STEP_REQ;
                    end
                end
                S_SHOW_ON: begin
                    if (tmr_done) begin
                        state        <= S_SHOW_OFF;
                        show_val_q   <= '0;
                        show_valid_q <= 1'b0;
                    end
                end
                S_SHOW_OFF: begin
                    if (tmr_done) begin
                        if (i == last) begin
                            state <= S_INPUT;
                            idx   <= '0;
                        end else begin
                            i            <= i_nxt;
                            state        <= S_SHOW_ON;
                            show_val_q   <= seq[i_nxt[AW-1:0]];
                            show_valid_q <= 1'b1;
                        end
                    end
                end
                S_INPUT: begin
                    if (bus.btn_valid) begin
                        if (!btn_match) begin
                            state  <= S_FAIL;
                            fail_q <= 1'b1;
                        end else if (idx == last) begin
                            if (len == LW'(MAX_LEN)) begin
                                state <= S_WIN;
                                win_q <= 1'b1;
                            end else begin
                                state  <= S_REQ;
                                step_q <= STEP_REQ;
                            end
                        end else begin
                            idx <= idx + LW'(1);
                        end
                    end else if (timeout_hit) begin
                        state  <= S_FAIL;
                        fail_q <= 1'b1;
                    end
                end
                S_WIN, S_FAIL: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.step       = step_q;
    assign bus.show_val   = show_val_q;
    assign bus.show_valid = show_valid_q;
    assign bus.level      = len;
    assign bus.busy       = busy_q;
    assign bus.win        = win_q;
    assign bus.fail       = fail_q;

endmodule
